// File: rtl/uart_port_ctrl_pkg.sv
// Shared types and default timing constants for the UART port sequencer.
package uart_port_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_W_SETUP   = 3'd1,
      S_W_STROBE  = 3'd2,
      S_W_HOLD    = 3'd3,
      S_W_WAIT_TX = 3'd4,
      S_R_WAIT_RX = 3'd5,
      S_R_STROBE  = 3'd6,
      S_RELEASE   = 3'd7
   } state_t;

   localparam int STROBE_CYCLES_DEF = 2;
   localparam int SETUP_CYCLES_DEF  = 1;
   localparam int TIMEOUT_DEF       = 1023;

   // Phase timer width; strobe/setup lengths are expected to stay well below 256.
   localparam int TMR_W = 8;

endpackage

// File: rtl/uart_port_ctrl_if.sv
// Request/response handshake between the data-memory controller and the UART port sequencer.
interface uart_port_ctrl_if;
   logic       req_read;
   logic       req_write;
   logic [7:0] wdata;
   logic       accept;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] rdata;

   modport master (
      output req_read, req_write, wdata,
      input  accept, busy, done, err, rdata
   );

   modport slave (
      input  req_read, req_write, wdata,
      output accept, busy, done, err, rdata
   );
endinterface

// File: rtl/uart_port_ctrl_sync2.sv
// Two-flop synchroniser with synchronous clear for the asynchronous UART status lines.
module uart_port_ctrl_sync2 (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge CLK) begin
      if (RST) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_port_ctrl.sv
// Sequences single-byte reads/writes to the UART chip that shares RAM1 data[7:0].
// state       | meaning
// IDLE        | bus released, waiting for a request
// W_SETUP     | write byte driven, wrn high
// W_STROBE    | wrn low
// W_HOLD      | wrn high, byte still driven
// W_WAIT_TX   | bus released, waiting for tbre then tsre
// R_WAIT_RX   | waiting for data_ready
// R_STROBE    | rdn low, byte captured on last cycle
// RELEASE     | bus turnaround before IDLE
module uart_port_ctrl
   import uart_port_ctrl_pkg::*;
#(
   parameter int STROBE_CYCLES = STROBE_CYCLES_DEF,
   parameter int SETUP_CYCLES  = SETUP_CYCLES_DEF,
   parameter int TIMEOUT       = TIMEOUT_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   uart_port_ctrl_if.slave host,
   output logic            rx_avail,
   output logic            tx_idle,
   input  logic [7:0]      bus_in,
   output logic [7:0]      bus_out,
   output logic            bus_oe,
   output logic            ram_disable,
   input  logic            data_ready,
   input  logic            tbre,
   input  logic            tsre,
   output logic            rdn,
   output logic            wrn
);
   localparam int               CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]    WAIT_MAX = CW'(TIMEOUT);
   localparam logic [TMR_W-1:0] STB_LOAD = TMR_W'(STROBE_CYCLES - 1);
   localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETUP_CYCLES - 1);

   logic rx_s, tbre_s, tsre_s;

   uart_port_ctrl_sync2 u_sync_rx   (.CLK(CLK), .RST(RST), .d(data_ready), .q(rx_s));
   uart_port_ctrl_sync2 u_sync_tbre (.CLK(CLK), .RST(RST), .d(tbre),       .q(tbre_s));
   uart_port_ctrl_sync2 u_sync_tsre (.CLK(CLK), .RST(RST), .d(tsre),       .q(tsre_s));

   assign rx_avail = rx_s;
   assign tx_idle  = tbre_s & tsre_s;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [CW-1:0]    wcnt_q, wcnt_d;
   logic             tx_seen_q, tx_seen_d;
   logic             fail_q, fail_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             accept_d, done_d, err_d, busy_d;
   logic             rdn_d, wrn_d, oe_d;
   logic [7:0]       bus_out_d;

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      wcnt_d    = wcnt_q;
      tx_seen_d = tx_seen_q;
      fail_d    = fail_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      accept_d  = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            fail_d    = 1'b0;
            tx_seen_d = 1'b0;
            wcnt_d    = '0;
            if (host.req_write) begin
               state_d  = S_W_SETUP;
               tmr_d    = SET_LOAD;
               wdata_d  = host.wdata;
               accept_d = 1'b1;
            end else if (host.req_read) begin
               state_d  = S_R_WAIT_RX;
               accept_d = 1'b1;
            end
         end
         S_W_SETUP: begin
            if (tmr_q == '0) begin
               state_d = S_W_STROBE;
               tmr_d   = STB_LOAD;
            end else tmr_d = tmr_q - TMR_W'(1);
         end
         S_W_STROBE: begin
            if (tmr_q == '0) state_d = S_W_HOLD;
            else tmr_d = tmr_q - TMR_W'(1);
         end
         S_W_HOLD: begin
            state_d   = S_W_WAIT_TX;
            wcnt_d    = '0;
            tx_seen_d = 1'b0;
         end
         S_W_WAIT_TX: begin
            // tbre is remembered once seen so tsre completing later still releases
            if ((tx_seen_q || tbre_s) && tsre_s) begin
               state_d = S_RELEASE;
               tmr_d   = SET_LOAD;
            end else if (wcnt_q == WAIT_MAX) begin
               state_d = S_RELEASE;
               tmr_d   = SET_LOAD;
               fail_d  = 1'b1;
            end else begin
               wcnt_d    = wcnt_q + CW'(1);
               tx_seen_d = tx_seen_q | tbre_s;
            end
         end
         S_R_WAIT_RX: begin
            if (rx_s) begin
               state_d = S_R_STROBE;
               tmr_d   = STB_LOAD;
            end else if (wcnt_q == WAIT_MAX) begin
               state_d = S_RELEASE;
               tmr_d   = SET_LOAD;
               fail_d  = 1'b1;
            end else wcnt_d = wcnt_q + CW'(1);
         end
         S_R_STROBE: begin
            if (tmr_q == '0) begin
               rdata_d = bus_in;
               state_d = S_RELEASE;
               tmr_d   = SET_LOAD;
            end else tmr_d = tmr_q - TMR_W'(1);
         end
         S_RELEASE: begin
            if (tmr_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else tmr_d = tmr_q - TMR_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // Pin values are decoded from the next state and registered, keeping strobes glitch-free
      busy_d    = (state_d != S_IDLE);
      wrn_d     = (state_d != S_W_STROBE);
      rdn_d     = (state_d != S_R_STROBE);
      oe_d      = (state_d == S_W_SETUP) || (state_d == S_W_STROBE) || (state_d == S_W_HOLD);
      bus_out_d = oe_d ? wdata_d : 8'h00;
      err_d     = done_d & fail_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         tmr_q        <= '0;
         wcnt_q       <= '0;
         tx_seen_q    <= 1'b0;
         fail_q       <= 1'b0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         host.accept  <= 1'b0;
         host.done    <= 1'b0;
         host.err     <= 1'b0;
         host.busy    <= 1'b0;
         rdn          <= 1'b1;
         wrn          <= 1'b1;
         bus_oe       <= 1'b0;
         bus_out      <= '0;
         ram_disable  <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         wcnt_q       <= wcnt_d;
         tx_seen_q    <= tx_seen_d;
         fail_q       <= fail_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         host.accept  <= accept_d;
         host.done    <= done_d;
         host.err     <= err_d;
         host.busy    <= busy_d;
         rdn          <= rdn_d;
         wrn          <= wrn_d;
         bus_oe       <= oe_d;
         bus_out      <= bus_out_d;
         ram_disable  <= busy_d;
      end
   end

   assign host.rdata = rdata_q;

endmodule

// File: tb/tb_uart_port_ctrl.sv
// Self-checking bench for uart_port_ctrl: directed cases plus random traffic against a timing model.
module tb_uart_port_ctrl;
   localparam int STB = 2;
   localparam int SET = 1;
   localparam int TO  = 15;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] bus_in, bus_out;
   logic       bus_oe, ram_disable, data_ready, tbre, tsre, rdn, wrn, rx_avail, tx_idle;

   uart_port_ctrl_if host ();

   uart_port_ctrl #(.STROBE_CYCLES(STB), .SETUP_CYCLES(SET), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .host(host),
      .rx_avail(rx_avail), .tx_idle(tx_idle),
      .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .ram_disable(ram_disable),
      .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
      .rdn(rdn), .wrn(wrn)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   int rdn_tot, wrn_tot, oe_tot, busy_tot, err_tot, acc_tot, done_tot;
   int acc_e, done_e, rdn_first;
   logic done_err;
   logic [7:0] bus_at_wrn;
   logic [7:0] exp_rdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      chk(tag, {31'd0, obs}, {31'd0, exp});
   endtask

   // One cycle: sample at the falling edge, check invariants, accumulate activity
   task automatic tick();
      @(negedge CLK);
      chkb("inv_strobes", rdn | wrn, 1'b1);
      chkb("inv_oe_rdis", !bus_oe | ram_disable, 1'b1);
      chkb("inv_rdn_oe", rdn | !bus_oe, 1'b1);
      chkb("inv_acc_done", !(host.accept & host.done), 1'b1);
      chkb("inv_err_done", !host.err | host.done, 1'b1);
      if (host.accept) begin acc_tot++; acc_e = cyc; end
      if (host.done) begin done_tot++; done_e = cyc; done_err = host.err; end
      if (host.err) err_tot++;
      if (!rdn) begin
         if (rdn_first < 0) rdn_first = cyc;
         rdn_tot++;
      end
      if (!wrn) begin wrn_tot++; bus_at_wrn = bus_out; end
      if (bus_oe) oe_tot++;
      if (host.busy) busy_tot++;
   endtask

   task automatic clear_rec();
      rdn_tot = 0; wrn_tot = 0; oe_tot = 0; busy_tot = 0; err_tot = 0;
      acc_tot = 0; done_tot = 0; acc_e = -1; done_e = -1; rdn_first = -1;
      done_err = 1'b0; bus_at_wrn = 8'h00;
   endtask

   // d1/d2: cycles after the accept edge at which a UART flag rises (<0 already high, 1000 never).
   // Write: d1 = tbre, d2 = tsre. Read: d1 = data_ready.
   task automatic run_op(input bit is_wr, input logic [7:0] val, input int d1, input int d2,
                         input bit spur);
      int a, w, s, rel, exp_done, r1, r2, t;
      bit exp_err;
      host.req_read  = 1'b0;
      host.req_write = 1'b0;
      if (is_wr) begin
         tbre = (d1 < 0); tsre = (d2 < 0); data_ready = 1'($urandom_range(0, 1));
         bus_in = 8'($urandom);
      end else begin
         data_ready = (d1 < 0); tbre = 1'($urandom_range(0, 1)); tsre = 1'($urandom_range(0, 1));
         bus_in = val;
      end
      repeat (4) tick();
      clear_rec();
      a  = cyc + 1;
      r1 = (d1 < 0) ? -100 : a + d1;
      r2 = (d2 < 0) ? -100 : a + d2;
      // A flag raised after edge r is visible to the sequencer's decision at edge r+3
      if (is_wr) begin
         w       = a + SET + STB + 1;
         t       = (r1 > r2) ? r1 : r2;
         rel     = (t + 3 > w + 1) ? t + 3 : w + 1;
         exp_err = (rel > w + 1 + TO);
         if (exp_err) rel = w + 1 + TO;
         s       = -1;
      end else begin
         s       = (r1 + 3 > a + 1) ? r1 + 3 : a + 1;
         exp_err = (s > a + 1 + TO);
         rel     = exp_err ? a + 1 + TO : s + STB;
      end
      exp_done = rel + SET;

      host.wdata = val;
      if (is_wr) host.req_write = 1'b1;
      else host.req_read = 1'b1;

      for (int i = 0; i < 300 && done_e < 0; i++) begin
         tick();
         if (acc_e >= 0) begin
            host.wdata = 8'($urandom);
            if (spur && cyc < exp_done) begin
               host.req_read  = 1'($urandom_range(0, 1));
               host.req_write = 1'($urandom_range(0, 1));
            end else begin
               host.req_read  = 1'b0;
               host.req_write = 1'b0;
            end
         end
         if (is_wr) begin
            if (d1 >= 0 && cyc == a + d1) tbre = 1'b1;
            if (d2 >= 0 && cyc == a + d2) tsre = 1'b1;
         end else if (d1 >= 0 && cyc == a + d1) data_ready = 1'b1;
      end
      host.req_read  = 1'b0;
      host.req_write = 1'b0;

      chk("accept_edge", acc_e, a);
      chk("accept_count", acc_tot, 1);
      chk("done_edge", done_e, exp_done);
      chkb("err_at_done", done_err, exp_err);
      chk("err_pulses", err_tot, {31'd0, exp_err});
      chk("busy_cycles", busy_tot, exp_done - a);
      if (is_wr) begin
         chk("wr_wrn_cycles", wrn_tot, STB);
         chk("wr_oe_cycles", oe_tot, SET + STB + 1);
         chk("wr_bus_byte", 32'(bus_at_wrn), 32'(val));
         chk("wr_rdn_cycles", rdn_tot, 0);
      end else begin
         chk("rd_wrn_cycles", wrn_tot, 0);
         chk("rd_oe_cycles", oe_tot, 0);
         chk("rd_rdn_cycles", rdn_tot, exp_err ? 0 : STB);
         if (!exp_err) begin
            chk("rd_strobe_start", rdn_first, s);
            exp_rdata = val;
         end
      end
      chk("rdata", 32'(host.rdata), 32'(exp_rdata));
   endtask

   function automatic int pick_d();
      case ($urandom_range(0, 3))
         0:       return -1;
         1:       return int'($urandom_range(0, 8));
         2:       return int'($urandom_range(9, 20));
         default: return 1000;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int sim_done, d1, d2;
      RST = 1'b1;
      host.req_read = 1'b0; host.req_write = 1'b0; host.wdata = 8'h00;
      bus_in = 8'h00; data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
      exp_rdata = 8'h00;
      clear_rec();
      repeat (2) tick();

      chkb("rst_rdn", rdn, 1'b1);
      chkb("rst_wrn", wrn, 1'b1);
      chkb("rst_bus_oe", bus_oe, 1'b0);
      chk("rst_bus_out", 32'(bus_out), 32'h0);
      chkb("rst_ram_disable", ram_disable, 1'b0);
      chkb("rst_busy", host.busy, 1'b0);
      chkb("rst_accept", host.accept, 1'b0);
      chkb("rst_done", host.done, 1'b0);
      chkb("rst_err", host.err, 1'b0);
      chk("rst_rdata", 32'(host.rdata), 32'h0);
      chkb("rst_rx_avail", rx_avail, 1'b0);
      chkb("rst_tx_idle", tx_idle, 1'b0);
      RST = 1'b0;
      tick();

      // Two-flop synchroniser latency on the status outputs
      data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1;
      tick();
      chkb("sync_rx_1", rx_avail, 1'b0);
      chkb("sync_tx_1", tx_idle, 1'b0);
      tick();
      chkb("sync_rx_2", rx_avail, 1'b1);
      chkb("sync_tx_2", tx_idle, 1'b1);
      data_ready = 1'b0;

      // Write with transmitter already idle: 6 cycles from accept to done
      run_op(1'b1, 8'h41, -1, -1, 1'b0);
      chk("wr_latency", done_e - acc_e, 6);

      // Read with data_ready rising 5 cycles after accept
      run_op(1'b0, 8'h5A, 5, 0, 1'b0);
      chk("rd_latency", done_e - acc_e, 5 + 3 + STB + SET);

      // Read timeout: rdata keeps 0x5A
      run_op(1'b0, 8'hC3, 1000, 0, 1'b0);
      chk("rd_timeout_latency", done_e - acc_e, 1 + TO + 1);

      // Write timeout waiting for the transmitter
      run_op(1'b1, 8'h99, 1000, 1000, 1'b0);

      // tbre first, tsre later
      run_op(1'b1, 8'h3C, 2, 9, 1'b0);

      // Simultaneous requests: write first, held read accepted right after done
      tbre = 1'b1; tsre = 1'b1; data_ready = 1'b1; bus_in = 8'h33;
      repeat (4) tick();
      clear_rec();
      host.wdata = 8'h7E; host.req_write = 1'b1; host.req_read = 1'b1;
      for (int i = 0; i < 100 && done_e < 0; i++) begin
         tick();
         if (acc_e >= 0) host.req_write = 1'b0;
      end
      sim_done = done_e;
      chk("sim_write_wrn", wrn_tot, STB);
      chk("sim_write_rdn", rdn_tot, 0);
      chk("sim_write_byte", 32'(bus_at_wrn), 32'h7E);
      for (int i = 0; i < 100 && acc_tot < 2; i++) tick();
      chk("sim_read_accept", acc_e, sim_done + 1);
      host.req_read = 1'b0;
      for (int i = 0; i < 100 && done_tot < 2; i++) tick();
      chk("sim_read_done_count", done_tot, 2);
      exp_rdata = 8'h33;
      chk("sim_read_rdata", 32'(host.rdata), 32'(exp_rdata));

      // Reset while wrn is low
      tbre = 1'b1; tsre = 1'b1;
      repeat (2) tick();
      clear_rec();
      host.wdata = 8'hA5; host.req_write = 1'b1;
      for (int i = 0; i < 50 && wrn_tot == 0; i++) begin
         tick();
         if (acc_e >= 0) host.req_write = 1'b0;
      end
      chkb("mid_wrn_low", wrn, 1'b0);
      RST = 1'b1;
      tick();
      chkb("rst_mid_wrn", wrn, 1'b1);
      chkb("rst_mid_rdn", rdn, 1'b1);
      chkb("rst_mid_bus_oe", bus_oe, 1'b0);
      chkb("rst_mid_busy", host.busy, 1'b0);
      chkb("rst_mid_ram_dis", ram_disable, 1'b0);
      chkb("rst_mid_done", host.done, 1'b0);
      RST = 1'b0;
      repeat (8) tick();
      chk("rst_mid_no_done", done_tot, 0);
      exp_rdata = 8'h00;
      chk("rst_mid_rdata", 32'(host.rdata), 32'(exp_rdata));

      // Random traffic with spurious requests while busy
      while (cyc < 11000) begin
         if ($urandom_range(0, 1) == 1) begin
            d1 = pick_d();
            d2 = (d1 < 0) ? pick_d() : (($urandom_range(0, 1) == 1) ? d1 + int'($urandom_range(0, 6)) : 1000);
            run_op(1'b1, 8'($urandom), d1, d2, 1'b1);
         end else begin
            run_op(1'b0, 8'($urandom), pick_d(), 0, 1'b1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_port_ctrl.md
Name: uart_port_ctrl

Overview:
- Sequencer for the board's byte-wide serial-port chip, which shares the low byte of the RAM1 data bus.
- Sits directly downstream of the data-memory controller in the MEM stage.
  - The controller issues one byte read or write request.
  - This block drives rdn/wrn with correct setup and strobe widths, and waits on data_ready/tbre/tsre.
  - It returns the byte or a completion pulse.
- The controller holds its pipeline stall while busy=1.

Parameters:
- STROBE_CYCLES, 2: cycles rdn/wrn are held low (≥1).
- SETUP_CYCLES, 1: cycles write data is driven before wrn falls, and cycles bus is released before idle (≥1).
- TIMEOUT, 1023: max cycles waited for data_ready, tbre or tsre before aborting; width = clog2(TIMEOUT+1).

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- req_read  in  1  level request: read one byte from the port.
- req_write  in  1  level request: write wdata to the port.
- wdata  in  8  byte to transmit, sampled at acceptance.
- accept  out  1  one-cycle pulse: request taken in IDLE.
- busy  out  1  high from the accepting cycle until the return to IDLE.
- done  out  1  one-cycle pulse: operation complete (rdata valid for reads).
- err  out  1  one-cycle pulse: timeout abort, coincident with done.
- rdata  out  8  last byte read; holds until the next read completes.
- rx_avail  out  1  synchronised data_ready, for status polling.
- tx_idle  out  1  synchronised (tbre & tsre).
- bus_in  in  8  ram1Data[7:0] as read from the pad.
- bus_out  out  8  value for ram1Data[7:0].
- bus_oe  out  1  drive ram1Data (upper byte driven 0 when set, tristated otherwise, at top level).
- ram_disable  out  1  forces RAM1 EN/OE/WE inactive while the port owns the bus.
- data_ready  in  1  async, from UART.
- tbre  in  1  async, from UART.
- tsre  in  1  async, from UART.
- rdn  out  1  UART read strobe, active-low.
- wrn  out  1  UART write strobe, active-low.

Behaviour:
- Synchronisers:
  - data_ready, tbre and tsre each pass through a 2-flop synchroniser.
  - All FSM decisions use the synchronised copies, so there is 2 cycles of input latency.
- Reset (RST=1 at a posedge):
  - State IDLE, all counters 0.
  - rdn=1, wrn=1, bus_oe=0, bus_out=0, ram_disable=0, busy=0, accept=0, done=0, err=0, rdata=0.
  - Synchroniser flops are cleared to 0.
  - Reset mid-operation aborts immediately: strobes go high and the bus is released on that same edge, with no done pulse.
- Acceptance, only in IDLE:
  - req_write=1 takes priority over req_read; a read asserted in the same cycle is not taken and must be held.
  - The accept pulse is registered on the accepting edge.
  - wdata is latched on that edge.
  - Requests outside IDLE are ignored and not queued.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, W_WAIT_TX, R_WAIT_RX, R_STROBE, RELEASE.
- Write path:
  - W_SETUP: bus_oe=1, bus_out=latched byte, ram_disable=1, wrn=1, for SETUP_CYCLES cycles.
  - W_STROBE: wrn=0 for STROBE_CYCLES cycles.
  - W_HOLD: wrn=1, data still driven, 1 cycle.
  - W_WAIT_TX: bus_oe=0; wait until tbre_s=1 and then tsre_s=1, tbre observed first.
  - Then RELEASE.
- Read path:
  - R_WAIT_RX: ram_disable=1, bus_oe=0; wait for data_ready_s=1.
  - R_STROBE: rdn=0 for STROBE_CYCLES cycles; rdata is captured from bus_in on the last strobe cycle.
  - Then RELEASE with rdn=1.
- RELEASE:
  - ram_disable=1, bus_oe=0, for SETUP_CYCLES cycles.
  - Then IDLE; done pulses on the transition edge into IDLE.
  - busy falls in that same cycle.
- Timeout:
  - The counter resets on entry to each wait state and increments each cycle the condition is false.
  - Reaching TIMEOUT goes to RELEASE, flagging err; err pulses together with done.
  - On a read timeout, rdata is unchanged.
- Invariants:
  - rdn and wrn are never both 0.
  - bus_oe=1 implies ram_disable=1.
  - rdn=0 implies bus_oe=0.
- Back-to-back: IDLE lasts at least 1 cycle between operations, so accept is never asserted in the cycle done is asserted.

Decomposition:
- Shared package holds the state encoding enum (3 bits) and the default strobe/setup/timeout constants.
- One natural sub-module, sync2: a 2-flop synchroniser with a synchronous clear, instantiated three times.

Test Plan:
- Write, defaults, tbre/tsre already 1:
  - req_write=1, wdata=0x41 → accept at cycle 1.
  - bus_out=0x41 with bus_oe=1 for 1 cycle, then wrn=0 for exactly 2 cycles, then 1 hold cycle.
  - done at cycle 7 (1 W_WAIT_TX + 1 RELEASE cycle), err=0.
- Read with delayed data_ready:
  - req_read=1; data_ready rises 5 cycles later; bus_in=0x5A.
  - rdn=0 for 2 cycles starting 2 cycles after the synchroniser; rdata=0x5A; done pulse; rdn never low before data_ready_s.
- Simultaneous requests:
  - req_read=req_write=1 → write executes first.
  - The read is accepted 1 cycle after done only if still held.
- Timeout:
  - TIMEOUT=15, req_read with data_ready=0 → done and err both pulse 1+15+1 cycles after accept.
  - rdata is unchanged and rdn is never low.
- Reset mid-strobe: RST asserted while wrn=0 → next edge gives wrn=1, bus_oe=0, busy=0, no done.
- Invariant monitor:
  - Run random request traffic for 10k cycles.
  - Assert !(rdn==0 && wrn==0), bus_oe→ram_disable, and that accept and done never coincide.
